// File: rtl/prga_fifo_pkg.sv
// prga_fifo_pkg
//   Shared constants for the prga_fifo block: encodings of the LOOKAHEAD
//   parameter so the top and any instantiating code name the read modes
//   the same way. Sizing stays in per-instance module parameters.
package prga_fifo_pkg;

  // Read-interface modes selected by the LOOKAHEAD parameter.
  localparam int unsigned READ_MODE_STANDARD = 0;  // data one cycle after rd
  localparam int unsigned READ_MODE_FWFT     = 1;  // head word shown on dout

endpackage : prga_fifo_pkg

// File: rtl/prga_fifo_core.sv
// prga_fifo_core
//   Standard-mode synchronous FIFO. It holds a circular buffer of
//   2**DEPTH_LOG2 words, pointers one bit wider than the address, registered
//   full/empty flags and a registered read-data output.
// Ports
//   clk   : clock, all state updates on the rising edge
//   rst   : synchronous active-low reset
//   full  : no write can be accepted this cycle
//   wr    : push din when full=0
//   din   : write data
//   empty : no word available to read
//   rd    : pop the head word when empty=0; it appears on dout next cycle
//   dout  : read data, held until the next accepted read
module prga_fifo_core #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  full,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  empty,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] dout
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH_LOG2:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0]   rd_ptr_q, rd_ptr_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  wr_en, rd_en;

  // Requests only take effect against the flags registered this cycle, so
  // a write while full or a read while empty changes nothing.
  assign wr_en = wr & ~full_q;
  assign rd_en = rd & ~empty_q;

  // Flags come from the next-state pointers. That keeps them registered
  // and still exact on the cycle after every push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q + {{DEPTH_LOG2{1'b0}}, wr_en};
    rd_ptr_d = rd_ptr_q + {{DEPTH_LOG2{1'b0}}, rd_en};
    empty_d  = (wr_ptr_d == rd_ptr_d);
    // Same slot address with a different wrap bit means the writer is a
    // full lap ahead of the reader.
    full_d   = (wr_ptr_d[DEPTH_LOG2] != rd_ptr_d[DEPTH_LOG2]) &&
               (wr_ptr_d[DEPTH_LOG2-1:0] == rd_ptr_d[DEPTH_LOG2-1:0]);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs, whatever order the blocks are evaluated in.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      if (rd_en) begin
        dout_q <= mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
      end
    end
  end

  // NOTE: the storage array has no reset. The pointers alone define which
  // entries are live, and leaving the array out of reset lets it map to RAM.
  always_ff @(posedge clk) begin
    if (rst && wr_en) begin
      mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= din;
    end
  end

  assign full  = full_q;
  assign empty = empty_q;
  assign dout  = dout_q;

endmodule : prga_fifo_core

// File: rtl/prga_fifo.sv
// prga_fifo
//   Single-clock FIFO for buffering between fabric and host. LOOKAHEAD=0
//   exposes the standard core, where data follows rd by one cycle.
//   LOOKAHEAD=1 adds a one-word output stage, so the head word is always
//   shown on dout while empty=0 and rd pops it. That mode holds one more word.
// Ports
//   clk   : clock, all state updates on the rising edge
//   rst   : synchronous active-low reset
//   full  : no write can be accepted this cycle
//   wr    : push din when full=0
//   din   : write data
//   empty : standard mode, nothing to read; lookahead mode, dout not valid
//   rd    : read request (standard) or pop acknowledge (lookahead)
//   dout  : read data
module prga_fifo
  import prga_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned LOOKAHEAD  = READ_MODE_STANDARD
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  full,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  empty,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] dout
);

  if (LOOKAHEAD == READ_MODE_STANDARD) begin : g_standard

    prga_fifo_core #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_core (
      .clk   (clk),
      .rst   (rst),
      .full  (full),
      .wr    (wr),
      .din   (din),
      .empty (empty),
      .rd    (rd),
      .dout  (dout)
    );

  end else begin : g_lookahead

    logic                  core_empty;
    logic                  core_rd;
    logic [DATA_WIDTH-1:0] core_dout;
    logic                  valid_q, valid_d;

    // The core's registered dout is the output word. valid_q records that
    // it holds an unpopped word. Refill whenever that slot is free or is
    // being popped, so back-to-back pops run at full rate.
    assign core_rd = ~core_empty & (~valid_q | rd);

    prga_fifo_core #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_core (
      .clk   (clk),
      .rst   (rst),
      .full  (full),
      .wr    (wr),
      .din   (din),
      .empty (core_empty),
      .rd    (core_rd),
      .dout  (core_dout)
    );

    // A refill wins over a pop: the popped word is replaced by the next one.
    always_comb begin
      valid_d = valid_q;
      if (core_rd) begin
        valid_d = 1'b1;
      end else if (rd) begin
        valid_d = 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst) begin
        valid_q <= 1'b0;
      end else begin
        valid_q <= valid_d;
      end
    end

    assign empty = ~valid_q;
    assign dout  = core_dout;

  end

endmodule : prga_fifo

// File: tb/tb_prga_fifo.sv
// tb_prga_fifo
//   Self-checking bench. It runs a standard-mode and a lookahead-mode
//   prga_fifo (DATA_WIDTH=8, DEPTH_LOG2=2) side by side. Expected values come
//   from a stimulus table, from hand-written corner sequences, and from
//   queue-based reference models driven by random traffic.
module tb_prga_fifo;

  localparam int DW = 8;
  localparam int DL = 2;
  localparam int STD_CAP = 1 << DL;        // standard-mode capacity
  localparam int LA_CAP  = (1 << DL) + 1;  // lookahead adds the output word

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          s_wr = 1'b0, s_rd = 1'b0, l_wr = 1'b0, l_rd = 1'b0;
  logic [DW-1:0] s_din = '0, l_din = '0;
  logic          s_full, s_empty, l_full, l_empty;
  logic [DW-1:0] s_dout, l_dout;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  prga_fifo #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL), .LOOKAHEAD(0)) u_std (
    .clk(clk), .rst(rst), .full(s_full), .wr(s_wr), .din(s_din),
    .empty(s_empty), .rd(s_rd), .dout(s_dout)
  );

  prga_fifo #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL), .LOOKAHEAD(1)) u_la (
    .clk(clk), .rst(rst), .full(l_full), .wr(l_wr), .din(l_din),
    .empty(l_empty), .rd(l_rd), .dout(l_dout)
  );

  // ---------------- reference models ----------------
  // Standard: a queue of stored words plus the last word handed out.
  logic [DW-1:0] sm_q[$];
  logic [DW-1:0] sm_dout;
  // Lookahead: a queue of every word the FIFO holds, with the edge number at
  // which each was written. The head is presented once it has been in the
  // FIFO for at least one edge and the previous head has been popped.
  logic [DW-1:0] lm_q[$];
  int            lm_stamp[$];
  bit            lm_pres;
  int            edge_no;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    sm_q.delete();
    sm_dout = '0;
    lm_q.delete();
    lm_stamp.delete();
    lm_pres = 1'b0;
    edge_no = 0;
  endtask

  task automatic model_edge(input bit ws, input logic [DW-1:0] ds, input bit rs,
                            input bit wl, input logic [DW-1:0] dl, input bit rl);
    bit s_full_m, s_empty_m, l_full_m;
    s_full_m  = (sm_q.size() == STD_CAP);
    s_empty_m = (sm_q.size() == 0);
    if (rs && !s_empty_m) sm_dout = sm_q.pop_front();
    if (ws && !s_full_m) sm_q.push_back(ds);

    l_full_m = (lm_q.size() == LA_CAP);
    if (rl && lm_pres) begin
      void'(lm_q.pop_front());
      void'(lm_stamp.pop_front());
      lm_pres = 1'b0;
    end
    if (!lm_pres && lm_q.size() > 0 && lm_stamp[0] < edge_no) lm_pres = 1'b1;
    if (wl && !l_full_m) begin
      lm_q.push_back(dl);
      lm_stamp.push_back(edge_no);
    end
    edge_no++;
  endtask

  task automatic model_compare();
    check("s_full",  s_full,  sm_q.size() == STD_CAP);
    check("s_empty", s_empty, sm_q.size() == 0);
    check("s_dout",  s_dout,  sm_dout);
    check("l_full",  l_full,  lm_q.size() == LA_CAP);
    check("l_empty", l_empty, !lm_pres);
    if (lm_pres) check("l_dout", l_dout, lm_q[0]);
  endtask

  // Drive both DUTs for one clock, advance the models, then compare on the
  // falling edge.
  task automatic step(input bit ws, input logic [DW-1:0] ds, input bit rs,
                      input bit wl, input logic [DW-1:0] dl, input bit rl);
    s_wr = ws; s_din = ds; s_rd = rs;
    l_wr = wl; l_din = dl; l_rd = rl;
    @(posedge clk);
    model_edge(ws, ds, rs, wl, dl, rl);
    @(negedge clk);
    model_compare();
  endtask

  // Hold reset for two edges while requesting a write of 0xAA.
  task automatic do_reset();
    rst = 1'b0;
    s_wr = 1'b1; s_din = 8'hAA; s_rd = 1'b0;
    l_wr = 1'b1; l_din = 8'hAA; l_rd = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    s_wr = 1'b0; l_wr = 1'b0;
    model_clear();
  endtask

  // ---------------- standard-mode table ----------------
  typedef struct {
    bit            wr;
    logic [DW-1:0] din;
    bit            rd;
    bit            exp_full;
    bit            exp_empty;
    logic [DW-1:0] exp_dout;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [DW-1:0] got[$];
    logic [DW-1:0] exp_next;

    // Expectations are the outputs after the edge each row is applied on.
    tbl = '{
      '{1, 8'h01, 0, 0, 0, 8'h00},
      '{1, 8'h02, 0, 0, 0, 8'h00},
      '{1, 8'h03, 0, 0, 0, 8'h00},
      '{1, 8'h04, 0, 1, 0, 8'h00},  // full after 4th write
      '{1, 8'h05, 0, 1, 0, 8'h00},  // dropped
      '{0, 8'h00, 1, 0, 0, 8'h01},
      '{0, 8'h00, 1, 0, 0, 8'h02},
      '{0, 8'h00, 1, 0, 0, 8'h03},
      '{0, 8'h00, 1, 0, 1, 8'h04},  // empty after 4th read
      '{0, 8'h00, 1, 0, 1, 8'h04},  // read while empty: dout held
      '{1, 8'h09, 1, 0, 0, 8'h04},  // wr+rd at empty: stored, dout held
      '{0, 8'h00, 1, 0, 1, 8'h09},  // proves 0x05 was never stored
      '{1, 8'h11, 0, 0, 0, 8'h09},
      '{1, 8'h22, 0, 0, 0, 8'h09},
      '{1, 8'h33, 0, 0, 0, 8'h09},
      '{1, 8'h44, 0, 1, 0, 8'h09},
      '{1, 8'h55, 1, 0, 0, 8'h11},  // wr+rd at full: read only
      '{0, 8'h00, 1, 0, 0, 8'h22},
      '{0, 8'h00, 1, 0, 0, 8'h33},
      '{0, 8'h00, 1, 0, 1, 8'h44}   // 0x55 was dropped
    };

    @(negedge clk);
    // ---- reset ----
    do_reset();
    check("rst_s_full",  s_full,  1'b0);
    check("rst_s_empty", s_empty, 1'b1);
    check("rst_s_dout",  s_dout,  8'h00);
    check("rst_l_full",  l_full,  1'b0);
    check("rst_l_empty", l_empty, 1'b1);
    // A read right after reset must find nothing stored.
    step(0, 0, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    check("rst_nostore_s", s_empty, 1'b1);
    check("rst_nostore_l", l_empty, 1'b1);

    // ---- standard-mode table ----
    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].wr, tbl[i].din, tbl[i].rd, 0, 0, 0);
      check($sformatf("tbl%0d_full", i),  s_full,  tbl[i].exp_full);
      check($sformatf("tbl%0d_empty", i), s_empty, tbl[i].exp_empty);
      check($sformatf("tbl%0d_dout", i),  s_dout,  tbl[i].exp_dout);
    end

    // ---- lookahead stream: write 0x00..0x3F with rd held high ----
    do_reset();
    got.delete();
    for (int i = 0; i < 64; i++) begin
      if (!l_empty) got.push_back(l_dout);  // popped on the coming edge
      step(0, 0, 0, 1, 8'(i), 1);
      if (i == 0) check("la_first_lat1", l_empty, 1'b1);
      if (i == 1) begin
        check("la_first_lat2", l_empty, 1'b0);
        check("la_first_dout", l_dout, 8'h00);
      end
    end
    for (int i = 0; i < 8; i++) begin  // bounded drain
      if (!l_empty) got.push_back(l_dout);
      step(0, 0, 0, 0, 0, 1);
    end
    check("la_stream_count", got.size(), 64);
    for (int i = 0; i < got.size() && i < 64; i++)
      check($sformatf("la_stream_%0d", i), got[i], 8'(i));

    // ---- lookahead capacity + wr/rd at full ----
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      step(0, 0, 0, 1, 8'(i), 0);
      if (i >= 2) check($sformatf("la_cap_head%0d", i), l_dout, 8'h01);
      check($sformatf("la_cap_full%0d", i), l_full, i >= 5);
    end
    // Pop 0x01 and attempt 0x77 in the same cycle: write must be dropped.
    step(0, 0, 0, 1, 8'h77, 1);
    check("la_full_wrrd_full", l_full, 1'b0);
    got.delete();
    for (int i = 0; i < 10; i++) begin
      if (!l_empty) got.push_back(l_dout);
      step(0, 0, 0, 0, 0, 1);
    end
    check("la_drain_count", got.size(), 4);
    for (int i = 0; i < got.size() && i < 4; i++)
      check($sformatf("la_drain_%0d", i), got[i], 8'(i + 2));
    check("la_drain_empty", l_empty, 1'b1);

    // ---- pointer wrap at half occupancy, both modes ----
    do_reset();
    step(1, 8'hA0, 0, 1, 8'hA0, 0);
    step(1, 8'hA1, 0, 1, 8'hA1, 0);
    for (int i = 2; i < 22; i++) begin
      step(1, 8'(8'hA0 + i), 1, 1, 8'(8'hA0 + i), 1);
      check($sformatf("wrap_nofull_%0d", i), s_full, 1'b0);
      check($sformatf("wrap_noempty_%0d", i), s_empty, 1'b0);
    end
    exp_next = 8'hA0 + 8'd19;  // last popped word in standard mode
    check("wrap_s_last", s_dout, exp_next);

    // ---- randomized traffic against the models ----
    do_reset();
    for (int i = 0; i < 600; i++) begin
      int wb;
      wb = (i < 200) ? 70 : (i < 400) ? 30 : 50;
      step($urandom_range(0, 99) < wb, 8'($urandom), $urandom_range(0, 99) < (100 - wb),
           $urandom_range(0, 99) < wb, 8'($urandom), $urandom_range(0, 99) < (100 - wb));
      if (i == 300) begin
        // Reset in the middle of traffic discards everything.
        do_reset();
        model_compare();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule : tb_prga_fifo
